// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - CAN transmit mailbox scheduler: lowest-ID arbitration, attempt tracking, bus intermission.
// Optional retry limit with per-mailbox abort and masking is enabled by defining CAN_RETRY_LIMIT_EN.
module can_tx_scheduler #(
  parameter int N_MBOX            = 4,
  parameter int CLKS_PER_BIT      = 10,
  parameter int INTERMISSION_BITS = 3,
  parameter int MAX_RETRY         = 8,
  localparam int SEL_W            = $clog2(N_MBOX)
) (
  input  logic                  Clock_TB,
  input  logic                  Reset,
  input  logic [N_MBOX-1:0]     i_Req,
  input  logic [11*N_MBOX-1:0]  i_ID,
  input  logic                  i_Tx_Done,
  input  logic                  i_Arb_Lost,
  input  logic                  i_Tx_Error,
  output logic                  o_Tx_Start,
  output logic [10:0]           o_Tx_ID,
  output logic [SEL_W-1:0]      o_Tx_Sel,
  output logic [N_MBOX-1:0]     o_Grant,
  output logic [N_MBOX-1:0]     o_Ack,
  output logic [N_MBOX-1:0]     o_Abort,
  output logic                  o_Busy
);

  localparam int IM_CYCLES = INTERMISSION_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = $clog2(IM_CYCLES + 1);

  if (N_MBOX < 2 || N_MBOX > 8 || MAX_RETRY < 1 || MAX_RETRY > 15 || IM_CYCLES < 1) begin : g_param_check
    $error("can_tx_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_TX, INTERMISSION} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_load;
  logic                w_done;
  logic                w_im_last;
  logic                w_found;
  logic [SEL_W-1:0]    w_win_sel;
  logic [10:0]         w_win_id;
  logic [N_MBOX-1:0]   w_eligible;

  logic [SEL_W-1:0]    r_sel;
  logic [10:0]         r_id;
  logic [N_MBOX-1:0]   r_grant;
  logic [N_MBOX-1:0]   r_ack;
  logic [CNT_W-1:0]    r_im_cnt;

`ifdef CAN_RETRY_LIMIT_EN
  logic [3:0]          r_retry [N_MBOX];
  logic [N_MBOX-1:0]   r_mask;
  logic [N_MBOX-1:0]   r_abort;
  logic                w_fail;
  logic [3:0]          w_retry_inc;

  assign w_eligible = i_Req & ~r_mask;
`else
  assign w_eligible = i_Req;
`endif

  // Strict less-than while scanning upward keeps the lowest index on equal IDs.
  always_comb begin
    w_found   = 1'b0;
    w_win_sel = '0;
    w_win_id  = '0;
    for (int k = 0; k < N_MBOX; k++) begin
      if (w_eligible[k] && (!w_found || (i_ID[11*k +: 11] < w_win_id))) begin
        w_found   = 1'b1;
        w_win_sel = SEL_W'(k);
        w_win_id  = i_ID[11*k +: 11];
      end
    end
  end

  assign w_im_last = (r_im_cnt == CNT_W'(IM_CYCLES - 1));

  always_ff @(posedge Clock_TB) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_load = 1'b1;
          w_next = START;
        end
      end
      START: w_next = WAIT_TX;
      WAIT_TX: begin
        if (i_Tx_Done) begin
          w_done = 1'b1;
          w_next = INTERMISSION;
        end else if (i_Arb_Lost || i_Tx_Error) begin
          w_next = INTERMISSION;
        end
      end
      INTERMISSION: begin
        if (w_im_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock_TB) begin
    if (Reset) begin
      r_sel    <= '0;
      r_id     <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_im_cnt <= '0;
    end else begin
      r_ack <= '0;
      if (w_load) begin
        r_sel   <= w_win_sel;
        r_id    <= w_win_id;
        r_grant <= N_MBOX'(1) << w_win_sel;
      end
      if (r_state == WAIT_TX && w_next == INTERMISSION) begin
        r_grant <= '0;
      end
      if (w_done) begin
        r_ack <= r_grant;
      end
      if (r_state == INTERMISSION && !w_im_last) begin
        r_im_cnt <= r_im_cnt + CNT_W'(1);
      end else begin
        r_im_cnt <= '0;
      end
    end
  end

`ifdef CAN_RETRY_LIMIT_EN
  // Done outranks arbitration loss, which outranks error.
  assign w_fail      = (r_state == WAIT_TX) && !i_Tx_Done && !i_Arb_Lost && i_Tx_Error;
  assign w_retry_inc = (r_retry[r_sel] == 4'hF) ? 4'hF : (r_retry[r_sel] + 4'd1);

  always_ff @(posedge Clock_TB) begin
    if (Reset) begin
      for (int k = 0; k < N_MBOX; k++) begin
        r_retry[k] <= '0;
      end
      r_mask  <= '0;
      r_abort <= '0;
    end else begin
      r_abort <= '0;
      for (int k = 0; k < N_MBOX; k++) begin
        if (!i_Req[k]) begin
          r_mask[k] <= 1'b0;
        end
      end
      if (w_done) begin
        r_retry[r_sel] <= '0;
      end else if (w_fail) begin
        if (w_retry_inc == 4'(MAX_RETRY)) begin
          r_retry[r_sel] <= '0;
          r_abort        <= r_grant;
          r_mask[r_sel]  <= 1'b1;
        end else begin
          r_retry[r_sel] <= w_retry_inc;
        end
      end
    end
  end

  assign o_Abort = r_abort;
`else
  assign o_Abort = '0;
`endif

  assign o_Tx_Start = (r_state == START);
  assign o_Tx_ID    = r_id;
  assign o_Tx_Sel   = r_sel;
  assign o_Grant    = r_grant;
  assign o_Ack      = r_ack;
  assign o_Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - randomized bench for can_tx_scheduler against a transaction-level reference model.
module tb_can_tx_scheduler;

  localparam int N    = 4;
  localparam int IM   = 30;
  localparam int MAXR = 8;

  logic            Clock_TB = 1'b0;
  logic            Reset;
  logic [N-1:0]    i_Req;
  logic [11*N-1:0] i_ID;
  logic            i_Tx_Done, i_Arb_Lost, i_Tx_Error;
  logic            o_Tx_Start;
  logic [10:0]     o_Tx_ID;
  logic [1:0]      o_Tx_Sel;
  logic [N-1:0]    o_Grant, o_Ack, o_Abort;
  logic            o_Busy;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           m_cnt [N];
  logic [N-1:0] m_mask;

  can_tx_scheduler dut (
    .Clock_TB   (Clock_TB),
    .Reset      (Reset),
    .i_Req      (i_Req),
    .i_ID       (i_ID),
    .i_Tx_Done  (i_Tx_Done),
    .i_Arb_Lost (i_Arb_Lost),
    .i_Tx_Error (i_Tx_Error),
    .o_Tx_Start (o_Tx_Start),
    .o_Tx_ID    (o_Tx_ID),
    .o_Tx_Sel   (o_Tx_Sel),
    .o_Grant    (o_Grant),
    .o_Ack      (o_Ack),
    .o_Abort    (o_Abort),
    .o_Busy     (o_Busy)
  );

  always #5 Clock_TB = ~Clock_TB;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_mask = '0;
  endfunction

  // Winner = smallest (id, index) pair, ranked by the single key id*N + index.
  function automatic int model_pick();
    int best_key = 0;
    int pick = -1;
    for (int k = 0; k < N; k++) begin
      if (i_Req[k] && !m_mask[k]) begin
        int key = int'(i_ID[11*k +: 11]) * N + k;
        if (pick < 0 || key < best_key) begin
          best_key = key;
          pick = k;
        end
      end
    end
    return pick;
  endfunction

  task automatic drive_req(input logic [N-1:0] r, input logic [11*N-1:0] ids);
    i_Req = r;
    i_ID  = ids;
    for (int k = 0; k < N; k++) if (!r[k]) m_mask[k] = 1'b0;
  endtask

  task automatic wait_start(output int waits);
    waits = 0;
    while (waits < 100) begin
      @(negedge Clock_TB);
      waits++;
      if (o_Tx_Start) break;
    end
  endtask

  task automatic expect_idle();
    logic seen = 1'b0;
    repeat (4) begin
      @(negedge Clock_TB);
      seen = seen | o_Busy | o_Tx_Start;
    end
    check_eq("masked_no_start", 64'(seen), 64'd0);
  endtask

  // st = {error, arb_lost, done}; nreq/nid are presented once the attempt is in flight.
  task automatic run_attempt(input logic [2:0] st, input logic [N-1:0] nreq, input logic [11*N-1:0] nid);
    int          w;
    int          sel;
    int          n;
    logic [10:0] exp_id;
    logic [N-1:0] exp_ack, exp_abort;
    sel    = model_pick();
    exp_id = i_ID[11*sel +: 11];
    wait_start(w);
    check_eq("start_latency", 64'(w), 64'd1);
    check_eq("tx_sel", 64'(o_Tx_Sel), 64'(sel));
    check_eq("tx_id", 64'(o_Tx_ID), 64'(exp_id));
    check_eq("grant", 64'(o_Grant), 64'(1 << sel));
    @(negedge Clock_TB);
    drive_req(nreq, nid);
    check_eq("start_one_cycle", 64'(o_Tx_Start), 64'd0);
    repeat ($urandom_range(0, 3)) @(negedge Clock_TB);
    check_eq("attempt_hold", 64'({o_Grant, o_Tx_ID, o_Busy}), 64'({N'(1 << sel), exp_id, 1'b1}));
    {i_Tx_Error, i_Arb_Lost, i_Tx_Done} = st;
    @(negedge Clock_TB);
    {i_Tx_Error, i_Arb_Lost, i_Tx_Done} = 3'b000;

    exp_ack   = '0;
    exp_abort = '0;
    if (st[0]) begin
      exp_ack    = N'(1 << sel);
      m_cnt[sel] = 0;
    end else if (!st[1] && st[2]) begin
      m_cnt[sel] = (m_cnt[sel] >= 15) ? 15 : m_cnt[sel] + 1;
`ifdef CAN_RETRY_LIMIT_EN
      if (m_cnt[sel] == MAXR) begin
        exp_abort   = N'(1 << sel);
        m_cnt[sel]  = 0;
        m_mask[sel] = i_Req[sel];
      end
`endif
    end
    check_eq("ack", 64'(o_Ack), 64'(exp_ack));
    check_eq("abort", 64'(o_Abort), 64'(exp_abort));
    check_eq("grant_cleared_busy", 64'({o_Grant, o_Busy}), 64'({N'(0), 1'b1}));

    n = 1;
    {i_Tx_Error, i_Arb_Lost, i_Tx_Done} = 3'($urandom_range(1, 7));
    @(negedge Clock_TB);
    {i_Tx_Error, i_Arb_Lost, i_Tx_Done} = 3'b000;
    n++;
    check_eq("stray_status_ignored", 64'({o_Ack, o_Abort, o_Tx_Start}), 64'd0);
    for (int c = 0; c < 100; c++) begin
      @(negedge Clock_TB);
      if (!o_Busy) break;
      n++;
    end
    check_eq("intermission_len", 64'(n), 64'(IM));
  endtask

  function automatic logic [11*N-1:0] rand_ids();
    logic [11*N-1:0] ids;
    for (int k = 0; k < N; k++) begin
      ids[11*k +: 11] = ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'(12'h100 + $urandom_range(0, 2));
    end
    return ids;
  endfunction

  function automatic logic [2:0] rand_status();
    return ($urandom_range(0, 1) == 0) ? 3'b100 : 3'($urandom_range(1, 7));
  endfunction

  initial begin
    logic [11*N-1:0] ids;
    int w;
    Reset = 1'b1;
    i_Req = '0;
    i_ID  = '0;
    {i_Tx_Error, i_Arb_Lost, i_Tx_Done} = 3'b000;
    model_reset();
    repeat (3) @(negedge Clock_TB);
    check_eq("reset_outputs", 64'({o_Tx_Start, o_Tx_ID, o_Tx_Sel, o_Grant, o_Ack, o_Abort, o_Busy}), 64'd0);
    Reset = 1'b0;

    // Lowest ID wins over lower index; success then full intermission.
    ids = {11'h0F0, 11'h000, 11'h123, 11'h000};
    drive_req(4'b1010, ids);
    run_attempt(3'b001, 4'b0000, ids);

    // Equal IDs resolve to lowest index, also after a lost arbitration.
    ids = {11'h7FF, 11'h200, 11'h7FF, 11'h200};
    drive_req(4'b0101, ids);
    run_attempt(3'b010, 4'b0101, ids);
    run_attempt(3'b001, 4'b0000, ids);

    // Done and error together: done wins.
    ids = {11'h000, 11'h050, 11'h000, 11'h000};
    drive_req(4'b0100, ids);
    run_attempt(3'b101, 4'b0100, ids);

    // Reset in the middle of an attempt.
    wait_start(w);
    check_eq("pre_reset_start", 64'(w), 64'd1);
    @(negedge Clock_TB);
    Reset = 1'b1;
    @(negedge Clock_TB);
    check_eq("midtx_reset_outputs", 64'({o_Tx_Start, o_Tx_ID, o_Tx_Sel, o_Grant, o_Ack, o_Abort, o_Busy}), 64'd0);
    Reset = 1'b0;
    model_reset();
    run_attempt(3'b001, 4'b0000, ids);

    // Consecutive errors on mailbox 1.
    ids = {11'h000, 11'h000, 11'h3A5, 11'h000};
    drive_req(4'b0010, ids);
    for (int i = 0; i <= MAXR; i++) begin
      if (model_pick() < 0) begin
        expect_idle();
        drive_req(4'b0000, ids);
        @(negedge Clock_TB);
        drive_req(4'b0010, ids);
      end
      run_attempt(3'b100, 4'b0010, ids);
    end
    drive_req(4'b0000, ids);
    @(negedge Clock_TB);

    // Randomized traffic with request/ID changes while attempts are in flight.
    for (int it = 0; it < 60; it++) begin
      if (model_pick() < 0) begin
        expect_idle();
        drive_req(N'($urandom), rand_ids());
      end else begin
        run_attempt(rand_status(), N'($urandom), rand_ids());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter N_MBOX, default 4, number of transmit mailboxes (2..8).
REQ-002 Parameter CLKS_PER_BIT, default 10, Clock_TB cycles per CAN bit time.
REQ-003 Parameter INTERMISSION_BITS, default 3, bit times of bus idle enforced after every frame attempt.
REQ-004 Parameter MAX_RETRY, default 8, error retries per mailbox before abort (1..15).
REQ-005 Clock_TB  in  1  single clock; all logic on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 i_Req  in  N_MBOX  level, mailbox k holds a pending frame.
REQ-008 i_ID  in  11*N_MBOX  standard identifier of mailbox k at bits [11k+10:11k].
REQ-009 i_Tx_Done  in  1  one-cycle pulse, transmitter finished frame successfully.
REQ-010 i_Arb_Lost  in  1  one-cycle pulse, transmitter lost bus arbitration.
REQ-011 i_Tx_Error  in  1  one-cycle pulse, stuffing/form error during transmission.
REQ-012 o_Tx_Start  out  1  one-cycle pulse launching a frame.
REQ-013 o_Tx_ID  out  11  identifier of granted mailbox, stable from o_Tx_Start until attempt ends.
REQ-014 o_Tx_Sel  out  clog2(N_MBOX)  index of granted mailbox.
REQ-015 o_Grant  out  N_MBOX  one-hot grant, held for the whole attempt.
REQ-016 o_Ack  out  N_MBOX  one-cycle pulse, mailbox k transmitted.
REQ-017 o_Abort  out  N_MBOX  one-cycle pulse, mailbox k abandoned.
REQ-018 o_Busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT_TX, INTERMISSION.
REQ-020 IDLE: if any eligible request, winner = lowest i_ID among eligible mailboxes; equal IDs resolved to lowest index; winner registered, go START.
REQ-021 Eligible = i_Req[k] high and mailbox k not masked (REQ-033).
REQ-022 START: o_Tx_Start high exactly one cycle, o_Grant/o_Tx_ID/o_Tx_Sel valid, go WAIT_TX; request in IDLE at cycle t gives o_Tx_Start at t+1.
REQ-023 WAIT_TX: ignore i_Req changes; deasserting i_Req does not abort an attempt in progress.
REQ-024 WAIT_TX, i_Tx_Done: o_Ack[sel] pulse next cycle, retry count of sel cleared, go INTERMISSION.
REQ-025 WAIT_TX, i_Arb_Lost: no count change, go INTERMISSION, then re-arbitrate normally.
REQ-026 WAIT_TX, i_Tx_Error: retry count of sel incremented (saturating 4 bits), go INTERMISSION.
REQ-027 Simultaneous status pulses: priority i_Tx_Done > i_Arb_Lost > i_Tx_Error; only highest acted on.
REQ-028 Status pulses outside WAIT_TX SHALL be ignored.
REQ-029 INTERMISSION: counter runs exactly INTERMISSION_BITS*CLKS_PER_BIT cycles, then IDLE; o_Grant cleared on entry.
REQ-030 Arbitration re-evaluated from current i_Req/i_ID on every IDLE entry; no stale winner reuse.
REQ-031 o_Ack, o_Abort, o_Tx_Start never high in the same cycle for the same mailbox.

Reset
REQ-032 Reset SHALL force IDLE, all outputs 0, intermission counter 0, all retry counts 0, all masks 0, from any state including mid-WAIT_TX; no o_Ack/o_Abort emitted for the interrupted attempt.

Configuration
REQ-033 Macro CAN_RETRY_LIMIT_EN defined: when an error makes retry count of sel equal MAX_RETRY, o_Abort[sel] pulses (same cycle o_Ack would), count cleared, mailbox k masked until i_Req[k] seen low.
REQ-034 Macro undefined: no abort, retries unlimited, o_Abort tied 0, mask logic absent; retry counters may be omitted.

Verification
REQ-035 Reset, i_Req=4'b1010, ID1=0x123, ID3=0x0F0 -> o_Tx_Start one cycle later, o_Tx_Sel=3, o_Tx_ID=0x0F0, o_Grant=4'b1000.
REQ-036 i_Tx_Done in WAIT_TX -> o_Ack=4'b1000 one cycle; o_Busy low exactly 30 cycles after INTERMISSION entry (defaults).
REQ-037 ID0=ID2=0x200 both requesting -> Sel=0; i_Arb_Lost -> after intermission re-start Sel=0, retry count unchanged.
REQ-038 i_Tx_Done and i_Tx_Error same cycle -> o_Ack pulses, count not incremented; Reset asserted mid-WAIT_TX -> IDLE, all outputs 0 next cycle.
REQ-039 CAN_RETRY_LIMIT_EN: 8 consecutive i_Tx_Error on mailbox 1 -> o_Abort=4'b0010 after 8th; mailbox 1 not re-granted until i_Req[1] drops and rises. Undefined: 9th start occurs, o_Abort stays 0.
